// File: rtl/seg_cap_pkg.sv
// rtl/seg_cap_pkg.sv - segment patterns, error codes and FSM states for seg_scan_capture
package seg_cap_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for hex glyphs 0..F
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MULTI   = 2'b01;
  localparam logic [1:0] ERR_UNKNOWN = 2'b10;
  localparam logic [1:0] ERR_BOTH    = 2'b11;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low seven-segment pattern to hex nibble decoder
module seg7_decode
  import seg_cap_pkg::*;
(
  input  logic [6:0] seg,
  output logic       known,
  output logic [3:0] nibble
);

  always_comb begin
    known  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - rebuilds scanned 7-seg digits, frame pulse and bus error flags
// Optional err_count output when SEG_CAP_ERRCNT_EN is defined.
module seg_scan_capture
  import seg_cap_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] DIGIT_MASK    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [7:0]  ans,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  valid,
  output logic        frame_done,
  output logic        err,
`ifdef SEG_CAP_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  output logic [1:0]  err_code
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

  logic [6:0]  seg_q;
  logic [7:0]  ans_q;
  logic [14:0] prev_q;
  logic [7:0]  seen;
  logic [7:0]  cnt, cnt_nx;
  state_t      state, state_nx;
  logic        single, multi, changed, cap, unk, full, ev;
  logic [2:0]  idx;
  logic [1:0]  ev_code;
  logic [7:0]  wr_mask;
  logic        known;
  logic [3:0]  nibble;

  seg7_decode u_dec (
    .seg    (seg_q),
    .known  (known),
    .nibble (nibble)
  );

  always_comb begin
    single = ($countones(~ans_q) == 1);
    multi  = ($countones(~ans_q) > 1);
    idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!ans_q[i]) idx = 3'(i);
    end
    changed = ({ans_q, seg_q} != prev_q);
  end

  // Exactly one capture attempt per anode dwell: SETTLE counts, HOLD waits for a change
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    unk      = 1'b0;
    case (state)
      IDLE: begin
        if (single) begin
          state_nx = SETTLE;
          cnt_nx   = 8'd1;
        end
      end
      SETTLE: begin
        if (changed) begin
          cnt_nx   = 8'd1;
          state_nx = single ? SETTLE : IDLE;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt + 8'd1 == SETTLE_LAST) begin
            state_nx = HOLD;
            cap      = known;
            unk      = !known;
          end
        end
      end
      HOLD: begin
        if (changed) begin
          cnt_nx   = 8'd1;
          state_nx = single ? SETTLE : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    full    = (DIGIT_MASK != 8'h00) && ((seen & DIGIT_MASK) == DIGIT_MASK);
    wr_mask = cap ? (8'h01 << idx) : 8'h00;
    ev_code = {unk, multi};
    ev      = |ev_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= 7'h7F;
      ans_q      <= 8'hFF;
      prev_q     <= {8'hFF, 7'h7F};
      state      <= IDLE;
      cnt        <= 8'd0;
      seen       <= 8'h00;
      digits     <= 32'h0;
      valid      <= 8'h00;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      seg_q      <= seg;
      ans_q      <= ans;
      prev_q     <= {ans_q, seg_q};
      state      <= state_nx;
      cnt        <= cnt_nx;
      frame_done <= full;
      // Clear on completion first so a same-cycle capture counts toward the next frame
      seen       <= (full ? 8'h00 : seen) | wr_mask;
      if (cap) begin
        digits[{idx, 2'b00} +: 4] <= nibble;
        valid[idx]                <= 1'b1;
      end
      if (ev) begin
        err <= 1'b1;
        if (!err || err_clr) err_code <= ev_code;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

`ifdef SEG_CAP_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 16'h0;
    end else if (err_clr) begin
      err_count <= ev ? 16'h1 : 16'h0;
    end else if (ev && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - directed self-checking bench for seg_scan_capture
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [7:0]  ans = 8'hFF;
  logic        err_clr = 1'b0;

  logic [31:0] digits1, digits2, digits3;
  logic [7:0]  valid1, valid2, valid3;
  logic        fd1, fd2, fd3;
  logic        err1, err2, err3;
  logic [1:0]  code1, code2, code3;
`ifdef SEG_CAP_ERRCNT_EN
  logic [15:0] cnt1, cnt2, cnt3;
`endif

  int npass = 0;
  int ntot  = 0;
  int nfd1  = 0;
  int nfd2  = 0;
  int nfd3  = 0;

  logic [6:0] pats [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_scan_capture #(.SETTLE_CYCLES(4), .DIGIT_MASK(8'hFF)) dut (
    .clk(clk), .rst(rst), .seg(seg), .ans(ans), .err_clr(err_clr),
    .digits(digits1), .valid(valid1), .frame_done(fd1), .err(err1),
`ifdef SEG_CAP_ERRCNT_EN
    .err_count(cnt1),
`endif
    .err_code(code1)
  );

  seg_scan_capture #(.SETTLE_CYCLES(4), .DIGIT_MASK(8'h0F)) dut_lo (
    .clk(clk), .rst(rst), .seg(seg), .ans(ans), .err_clr(err_clr),
    .digits(digits2), .valid(valid2), .frame_done(fd2), .err(err2),
`ifdef SEG_CAP_ERRCNT_EN
    .err_count(cnt2),
`endif
    .err_code(code2)
  );

  seg_scan_capture #(.SETTLE_CYCLES(4), .DIGIT_MASK(8'h00)) dut_none (
    .clk(clk), .rst(rst), .seg(seg), .ans(ans), .err_clr(err_clr),
    .digits(digits3), .valid(valid3), .frame_done(fd3), .err(err3),
`ifdef SEG_CAP_ERRCNT_EN
    .err_count(cnt3),
`endif
    .err_code(code3)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (fd1) nfd1++;
    if (fd2) nfd2++;
    if (fd3) nfd3++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic scan(input int d, input int n);
    ans = 8'hFF ^ (8'h01 << d);
    seg = pats[d];
    repeat (n) step();
  endtask

  task automatic do_reset();
    ans = 8'hFF;
    seg = 7'h7F;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    nfd1 = 0;
    nfd2 = 0;
    nfd3 = 0;
  endtask

  initial begin
    step();
    step();
    chk("rst_digits", digits1, 32'h0);
    chk("rst_valid", {24'h0, valid1}, 32'h0);
    chk("rst_frame_done", {31'h0, fd1}, 32'h0);
    chk("rst_err", {31'h0, err1}, 32'h0);
    chk("rst_err_code", {30'h0, code1}, 32'h0);
    rst = 1'b0;
    step();

    // single dwell: write lands on the 5th edge after the value is driven
    ans = 8'hFE;
    seg = 7'h30;
    repeat (4) step();
    chk("settle_e4_valid", {24'h0, valid1}, 32'h0);
    step();
    chk("settle_e5_valid", {24'h0, valid1}, 32'h01);
    chk("settle_e5_digits", digits1, 32'h3);
    repeat (5) step();
    chk("settle_hold_digits", digits1, 32'h3);
    chk("settle_hold_valid", {24'h0, valid1}, 32'h01);

    // full scan twice
    nfd1 = 0;
    nfd2 = 0;
    for (int d = 0; d < 8; d++) scan(d, 8);
    chk("scan1_digits", digits1, 32'h76543210);
    chk("scan1_valid", {24'h0, valid1}, 32'hFF);
    chk("scan1_frames", nfd1, 1);
    chk("scan1_frames_lo", nfd2, 1);
    for (int d = 0; d < 8; d++) scan(d, 8);
    chk("scan2_frames", nfd1, 2);
    chk("scan2_digits", digits1, 32'h76543210);

    // glitching segments never settle
    do_reset();
    ans = 8'hFE;
    for (int k = 0; k < 5; k++) begin
      seg = 7'h30;
      step();
      step();
      seg = 7'h24;
      step();
      step();
    end
    ans = 8'hFF;
    repeat (4) step();
    chk("glitch_valid", {24'h0, valid1}, 32'h0);
    chk("glitch_digits", digits1, 32'h0);
    chk("glitch_err", {31'h0, err1}, 32'h0);

    // multi-anode then unknown pattern: first cause sticks
    ans = 8'hFC;
    step();
    ans = 8'hFF;
    step();
    chk("multi_err", {31'h0, err1}, 32'h1);
    chk("multi_code", {30'h0, code1}, 32'h1);
    ans = 8'hFB;
    seg = 7'h7F;
    repeat (8) step();
    chk("unk_after_multi_code", {30'h0, code1}, 32'h1);
    chk("unk_no_write", {24'h0, valid1}, 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err", {31'h0, err1}, 32'h0);
    chk("clr_code", {30'h0, code1}, 32'h0);
    ans = 8'hFF;
    step();
    step();
    ans = 8'hF7;
    seg = 7'h7F;
    repeat (8) step();
    chk("unk_err", {31'h0, err1}, 32'h1);
    chk("unk_code", {30'h0, code1}, 32'h2);
    chk("unk_valid", {24'h0, valid1}, 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr2_err", {31'h0, err1}, 32'h0);
    ans = 8'hFF;
    step();
    step();

    // async reset mid-scan
    do_reset();
    for (int d = 0; d < 4; d++) scan(d, 8);
    chk("lo_mask_frames", nfd2, 1);
    chk("ff_mask_no_frame", nfd1, 0);
    chk("part_digits", digits1, 32'h00003210);
    ans = 8'hEF;
    seg = pats[4];
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_digits", digits1, 32'h0);
    chk("async_rst_valid", {24'h0, valid1}, 32'h0);
    chk("async_rst_err", {31'h0, err1}, 32'h0);
    step();
    rst = 1'b0;
    repeat (8) step();
    for (int d = 5; d < 8; d++) scan(d, 8);
    chk("post_rst_no_frame", nfd1, 0);
    chk("post_rst_valid", {24'h0, valid1}, 32'hF0);
    chk("post_rst_digits", digits1, 32'h76540000);
    for (int d = 0; d < 4; d++) scan(d, 8);
    chk("post_rst_frame", nfd1, 1);
    chk("post_rst_digits_full", digits1, 32'h76543210);
    chk("post_rst_frames_lo", nfd2, 2);

    // three multi-anode cycles
    do_reset();
    ans = 8'hFC;
    step();
    step();
    step();
    ans = 8'hFF;
    step();
    step();
    chk("multi3_err", {31'h0, err1}, 32'h1);
    chk("multi3_code", {30'h0, code1}, 32'h1);
`ifdef SEG_CAP_ERRCNT_EN
    chk("multi3_count", {16'h0, cnt1}, 32'h3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("count_clr", {16'h0, cnt1}, 32'h0);
`endif

    chk("mask_zero_frames", nfd3, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Passive receiver for the multiplexed seven-segment display bus that `top` drives on `seg`/`ans`. It watches the scanned anode and segment lines and rebuilds the eight displayed hex digits. It also reports frame completion and flags illegal bus states. It sits beside `top` in the `sim` bench, and optionally on-board, as a self-checking observer of the display writer.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: consecutive cycles `{ans,seg}` must hold unchanged before a digit is sampled (2..255).
- `DIGIT_MASK`, 8'hFF: digit positions that must be captured for a frame to complete.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous active-high reset.
- `seg`  input  7  segment lines {g,f,e,d,c,b,a}, active-low.
- `ans`  input  8  anode enables, active-low, one digit at a time.
- `err_clr`  input  1  synchronous clear of `err`/`err_code`.
- `digits`  output  32  captured nibbles; digit i at [4i+3:4i].
- `valid`  output  8  digit i captured at least once since reset.
- `frame_done`  output  1  one-cycle pulse when every `DIGIT_MASK` digit has been captured since the last pulse.
- `err`  output  1  sticky error flag.
- `err_code`  output  2  first error cause: 01 multi-anode, 10 unknown pattern, 11 both in same cycle.

## Operation
- Inputs are registered once (`seg_q`, `ans_q`). All decisions use the registered values.
- Reset values: `digits`=0, `valid`=0, `frame_done`=0, `err`=0, `err_code`=0, settle counter=0, seen mask=0, state=IDLE.
- Anode classification of `ans_q`:
  - none: all ones.
  - single: exactly one zero, index i.
  - multi: two or more zeros.
- Decode table (`seg_q` → nibble), active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other pattern is unknown.
- State machine:
  - IDLE: anode none or multi. When a single anode appears: go to SETTLE, counter=1.
  - SETTLE: each cycle `{ans_q,seg_q}` equals the previous cycle, counter increments. Any change restarts the counter at 1; if the new anode class is not single, go to IDLE.
  - When counter reaches `SETTLE_CYCLES`:
    - If the pattern is known: write the nibble to digit i, set `valid[i]` and seen[i], go to HOLD.
    - If the pattern is unknown: raise the error, go to HOLD, no write.
  - HOLD: stays until `{ans_q,seg_q}` changes, then re-enters SETTLE (single anode) or IDLE. This gives one capture per anode dwell.
- Frame completion:
  - When `(seen & DIGIT_MASK) == DIGIT_MASK`, `frame_done` pulses for one cycle and seen clears.
  - A capture in that same cycle sets its seen bit after the clear, so it counts toward the next frame.
  - `digits` and `valid` persist across frames.
- Errors:
  - Multi-anode is flagged in any cycle where `ans_q` is multi. Unknown pattern is flagged only at the settle point.
  - `err` is sticky. `err_code` latches the first cause only.
  - `err_clr` clears both. If a new error occurs in the same cycle, the new error wins.
- `DIGIT_MASK`=0: `frame_done` never pulses.

## Timing
- Capture latency: input change at edge N → registered at N+1 → `digits`/`valid` update at edge N+1+`SETTLE_CYCLES`.
- `frame_done` is asserted the cycle after the completing capture becomes visible.
- Async `rst` mid-dwell: all state clears immediately. After release, the current dwell is re-settled from count 1.
- Glitches shorter than `SETTLE_CYCLES` never write a digit.

## Configuration
- `SEG_CAP_ERRCNT_EN` defined:
  - Adds output `err_count` [15:0], counting every error event. It saturates at FFFF.
  - It is cleared by `rst` and `err_clr`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `seg_cap_pkg`:
  - the 16 segment pattern constants
  - the `err_code` encodings
  - the state enum {IDLE, SETTLE, HOLD}
- Sub-module `seg7_decode`: combinational, `seg`[6:0] → {known, nibble[3:0]}.
- `seg_scan_capture` holds the registers, FSM, counters and frame logic.

## Test plan
- Reset (`SETTLE_CYCLES`=4): drive ans=FE, seg=30 for 10 cycles → `digits`[3:0]=3, `valid`=01, exactly one write, on edge 5 after the first registered cycle.
- Scan digits 0..7 showing 0..7, 8 cycles per dwell → `digits`=76543210, `valid`=FF, one `frame_done` pulse after digit 7. A second identical scan → second pulse.
- ans=FE with seg toggling 30/24 every 2 cycles for 20 cycles → no capture, `valid`=00, `err`=0.
- ans=FC for 1 cycle → `err`=1, `err_code`=01. Then seg=7F settled on ans=FB → `err_code` stays 01. Pulse `err_clr` → `err`=0, `err_code`=00.
- Assert `rst` in mid-scan after 4 digits → all outputs zero immediately. Resume the scan → a full frame is needed before `frame_done`.
- `DIGIT_MASK`=0F: scan digits 0..3 only → `frame_done` pulses. With `SEG_CAP_ERRCNT_EN`, 3 multi-anode cycles → `err_count`=3.
